// File: rtl/iq_integrator.sv
// Windowed fs/4 quadrature integrator: mixes real ADC samples against +/-1/0 references
// and emits one signed 32-bit (I, Q) pair per trigger with a single-cycle data_in strobe.
module iq_integrator #(
  parameter int ADC_W = 16,
  parameter int WIN_W = 10
) (
  input  logic                    clk100,
  input  logic                    rst_n,
  input  logic                    trigger,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    adc_valid,
  input  logic signed [ADC_W-1:0] adc_data,
  output logic                    busy,
  output logic                    data_in,
  output logic signed [31:0]      i_val,
  output logic signed [31:0]      q_val,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t             state;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   cnt;
  logic [1:0]         phase;
  logic signed [31:0] acc_i;
  logic signed [31:0] acc_q;
  logic signed [31:0] x_ext;
  logic signed [31:0] acc_i_nxt;
  logic signed [31:0] acc_q_nxt;
  logic               last;

  assign x_ext = {{(32-ADC_W){adc_data[ADC_W-1]}}, adc_data};
  assign last  = (WIN_W'(cnt + 1'b1) == win_q);

  // fs/4 reference: cos = 1,0,-1,0 and sin = 0,1,0,-1, so each phase touches one accumulator.
  always_comb begin
    acc_i_nxt = acc_i;
    acc_q_nxt = acc_q;
    case (phase)
      2'd0:    acc_i_nxt = acc_i + x_ext;
      2'd1:    acc_q_nxt = acc_q + x_ext;
      2'd2:    acc_i_nxt = acc_i - x_ext;
      default: acc_q_nxt = acc_q - x_ext;
    endcase
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      win_q   <= '0;
      cnt     <= '0;
      phase   <= '0;
      acc_i   <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      data_in <= 1'b0;
      i_val   <= '0;
      q_val   <= '0;
      overrun <= 1'b0;
    end else begin
      data_in <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger && (win_len != '0)) begin
            win_q <= win_len;
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
            phase <= '0;
            busy  <= 1'b1;
            state <= INTEG;
          end
        end
        INTEG: begin
          if (trigger) overrun <= 1'b1;
          if (adc_valid) begin
            acc_i <= acc_i_nxt;
            acc_q <= acc_q_nxt;
            cnt   <= cnt + 1'b1;
            phase <= phase + 1'b1;
            // Result is registered on the final sample so it is already valid during EMIT.
            if (last) begin
              i_val   <= acc_i_nxt;
              q_val   <= acc_q_nxt;
              data_in <= 1'b1;
              state   <= EMIT;
            end
          end
        end
        EMIT: begin
          if (trigger) overrun <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_integrator.sv
// Directed bench for iq_integrator: results are queued when a window is driven and
// compared by a strobe monitor; cycle-exact checks are made inline.
module tb_iq_integrator;

  logic               clk100 = 1'b0;
  logic               rst_n  = 1'b0;
  logic               trigger = 1'b0;
  logic [9:0]         win_len = '0;
  logic               adc_valid = 1'b0;
  logic signed [15:0] adc_data = '0;
  logic               busy;
  logic               data_in;
  logic signed [31:0] i_val;
  logic signed [31:0] q_val;
  logic               overrun;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int pushes = 0;
  logic [63:0] exp_q[$];

  iq_integrator #(.ADC_W(16), .WIN_W(10)) dut (
    .clk100(clk100), .rst_n(rst_n), .trigger(trigger), .win_len(win_len),
    .adc_valid(adc_valid), .adc_data(adc_data), .busy(busy), .data_in(data_in),
    .i_val(i_val), .q_val(q_val), .overrun(overrun)
  );

  always #5 clk100 = ~clk100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic signed [31:0] ei, input logic signed [31:0] eq);
    exp_q.push_back({ei, eq});
    pushes++;
  endtask

  // Drive one cycle of inputs, then return 1ns after the edge that samples them.
  task automatic cyc(input logic t, input logic [9:0] w, input logic v, input logic [15:0] d);
    trigger   = t;
    win_len   = w;
    adc_valid = v;
    adc_data  = d;
    @(posedge clk100);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_async_flags", 64'({busy, data_in, overrun}), 64'd0);
    chk("reset_async_iq", {i_val, q_val}, 64'd0);
    cyc(1'b1, 10'd4, 1'b1, 16'd7);
    rst_n = 1'b1;
  endtask

  always @(negedge clk100) begin
    if (rst_n === 1'b1 && data_in === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_strobe observed=%0h expected=none", {i_val, q_val});
      end else begin
        chk("strobe_iq", {i_val, q_val}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset with random inputs
    for (int k = 0; k < 4; k++) begin
      cyc(1'($urandom), 10'($urandom), 1'($urandom), 16'($urandom));
      chk("reset_flags", 64'({busy, data_in, overrun}), 64'd0);
      chk("reset_iq", {i_val, q_val}, 64'd0);
    end
    rst_n = 1'b1;
    cyc(1'b0, 10'd0, 1'b0, 16'd0);
    chk("post_reset_busy_strobe", 64'({busy, data_in}), 64'd0);

    // Continuous window of 4
    cyc(1'b1, 10'd4, 1'b1, 16'd999);
    chk("cont_busy_after_trig", 64'(busy), 64'd1);
    push(-32'sd20, -32'sd20);
    cyc(1'b0, 10'd0, 1'b1, 16'd10);
    cyc(1'b0, 10'd0, 1'b1, 16'd20);
    cyc(1'b0, 10'd0, 1'b1, 16'd30);
    chk("cont_no_early_strobe", 64'(data_in), 64'd0);
    cyc(1'b0, 10'd0, 1'b1, 16'd40);
    chk("cont_strobe_busy", 64'({data_in, busy}), 64'b11);
    chk("cont_iq", {i_val, q_val}, {-32'sd20, -32'sd20});
    cyc(1'b0, 10'd0, 1'b1, 16'd50);
    chk("cont_end", 64'({data_in, busy}), 64'd0);
    chk("cont_hold_iq", {i_val, q_val}, {-32'sd20, -32'sd20});

    // Gapped window of 8
    cyc(1'b1, 10'd8, 1'b0, 16'd0);
    push(-32'sd4, -32'sd4);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 10'd0, 1'b1, 16'(k));
      if (k < 8) begin
        chk("gap_no_strobe", 64'({data_in, busy}), 64'b01);
        cyc(1'b0, 10'd0, 1'b0, 16'($urandom));
        chk("gap_idle_cycle", 64'({data_in, busy}), 64'b01);
      end
    end
    chk("gap_strobe", 64'(data_in), 64'd1);
    chk("gap_iq", {i_val, q_val}, {-32'sd4, -32'sd4});
    cyc(1'b0, 10'd0, 1'b0, 16'd0);

    // Overrun mid-window
    chk("ovr_clear", 64'(overrun), 64'd0);
    cyc(1'b1, 10'd4, 1'b0, 16'd0);
    push(-32'sd20, -32'sd20);
    cyc(1'b0, 10'd0, 1'b1, 16'd10);
    cyc(1'b0, 10'd0, 1'b1, 16'd20);
    cyc(1'b1, 10'd2, 1'b0, 16'd0);
    chk("ovr_set", 64'({overrun, busy}), 64'b11);
    cyc(1'b0, 10'd0, 1'b1, 16'd30);
    cyc(1'b0, 10'd0, 1'b1, 16'd40);
    chk("ovr_result", {i_val, q_val}, {-32'sd20, -32'sd20});
    cyc(1'b0, 10'd0, 1'b0, 16'd0);

    // Trigger on strobe cycle is an overrun; the next cycle starts a window
    pulse_reset();
    cyc(1'b0, 10'd0, 1'b0, 16'd0);
    chk("ovr_cleared_by_reset", 64'(overrun), 64'd0);
    cyc(1'b1, 10'd2, 1'b0, 16'd0);
    push(32'sd3, 32'sd4);
    cyc(1'b0, 10'd0, 1'b1, 16'd3);
    cyc(1'b0, 10'd0, 1'b1, 16'd4);
    chk("emit_strobe", 64'(data_in), 64'd1);
    cyc(1'b1, 10'd2, 1'b0, 16'd0);
    chk("emit_trig_overrun", 64'({overrun, busy}), 64'b10);
    cyc(1'b1, 10'd1, 1'b1, 16'd999);
    chk("retrig_busy", 64'({busy, data_in}), 64'b10);
    push(32'sd5, 32'sd0);
    cyc(1'b0, 10'd0, 1'b1, 16'd5);
    chk("retrig_iq", {i_val, q_val}, {32'sd5, 32'sd0});
    cyc(1'b0, 10'd0, 1'b0, 16'd0);

    // Zero length, then single negative full-scale sample
    cyc(1'b1, 10'd0, 1'b1, 16'd7);
    chk("zero_len_busy", 64'(busy), 64'd0);
    cyc(1'b0, 10'd0, 1'b1, 16'd7);
    chk("zero_len_no_strobe", 64'({busy, data_in}), 64'd0);
    cyc(1'b1, 10'd1, 1'b0, 16'd0);
    push(-32'sd32768, 32'sd0);
    cyc(1'b0, 10'd0, 1'b1, 16'h8000);
    chk("neg_strobe", 64'(data_in), 64'd1);
    chk("neg_iq", {i_val, q_val}, {32'hFFFF8000, 32'h0});
    cyc(1'b0, 10'd0, 1'b0, 16'd0);

    // Reset mid-window aborts with no strobe
    cyc(1'b1, 10'd4, 1'b0, 16'd0);
    cyc(1'b0, 10'd0, 1'b1, 16'd10);
    cyc(1'b0, 10'd0, 1'b1, 16'd20);
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 10'd0, 1'b1, 16'd30);
      chk("abort_quiet", 64'({busy, data_in}), 64'd0);
    end
    cyc(1'b1, 10'd4, 1'b0, 16'd0);
    push(-32'sd20, -32'sd20);
    cyc(1'b0, 10'd0, 1'b1, 16'd10);
    cyc(1'b0, 10'd0, 1'b1, 16'd20);
    cyc(1'b0, 10'd0, 1'b1, 16'd30);
    cyc(1'b0, 10'd0, 1'b1, 16'd40);
    chk("fresh_iq", {i_val, q_val}, {-32'sd20, -32'sd20});
    cyc(1'b0, 10'd0, 1'b0, 16'd0);
    cyc(1'b0, 10'd0, 1'b0, 16'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("strobe_count", 64'(strobes), 64'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
